// File: rtl/gate_lane_rr_arbiter.sv
// Round-robin arbiter sharing one registered NAND2/INV/BUF gate unit among NUM_REQ requesters.
// Optional completed-response counter enabled by the GATE_ARB_STATS_EN macro.
module gate_lane_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a1,
    input  logic [DATA_W*NUM_REQ-1:0] req_a2,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic [15:0]               stat_count
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // req_ready never depends on op/data; rsp_* hold steady while rsp_valid & ~rsp_ready.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                can_accept;
    logic                accept;
    int                  idx;
    logic [1:0]          sel_op;
    logic [DATA_W-1:0]   sel_a1, sel_a2;
    logic [DATA_W-1:0]   gate_data;
    logic                gate_err;

    // Rotating priority search starting at the pointer; wraps past NUM_REQ-1 back to 0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign accept     = grant_any && can_accept;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_op = req_op[2*int'(grant_idx) +: 2];
    assign sel_a1 = req_a1[DATA_W*int'(grant_idx) +: DATA_W];
    assign sel_a2 = req_a2[DATA_W*int'(grant_idx) +: DATA_W];

    always_comb begin
        gate_data = '0;
        gate_err  = 1'b0;
        case (sel_op)
            2'b00:   gate_data = ~(sel_a1 & sel_a2);
            2'b01:   gate_data = ~sel_a1;
            2'b10:   gate_data = sel_a1;
            default: gate_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    assign rsp_valid = (state_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_id   <= grant_idx;
            rsp_data <= gate_data;
            rsp_err  <= gate_err;
        end
    end

`ifdef GATE_ARB_STATS_EN
    logic [15:0] stat_q;

    // Saturates rather than wrapping so a long run never reads back as a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= 16'h0000;
        end else if (rsp_valid && rsp_ready && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_count = stat_q;
`else
    assign stat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_lane_rr_arbiter.sv
// Bench for gate_lane_rr_arbiter: table-driven single requests, then fairness,
// backpressure, async reset and stat counter sequences with a response scoreboard.
module tb_gate_lane_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + DATA_W + 1;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a1;
  logic [DATA_W*NUM_REQ-1:0] req_a2;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [15:0]               stat_count;

  gate_lane_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a1(req_a1), .req_a2(req_a2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stat_count(stat_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    req_valid = '0;
    req_op    = '0;
    req_a1    = '0;
    req_a2    = '0;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a1, input logic [7:0] a2);
    req_valid[id]               = 1'b1;
    req_op[2*id +: 2]           = op;
    req_a1[DATA_W*id +: DATA_W] = a1;
    req_a2[DATA_W*id +: DATA_W] = a2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string name, input int id, input logic [7:0] data, input logic err);
    logic [3:0] m;
    m = 4'(1 << id);
    check(name, 32'(req_ready), 32'(m));
    exp_q.push_back({2'(id), data, err});
  endtask

  task automatic drain();
    clear_inputs();
    @(negedge clk);
    next_cycle();
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0h, expected none", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e[W-1 -: ID_W]));
        check("rsp_data", 32'(rsp_data), 32'(e[DATA_W:1]));
        check("rsp_err", 32'(rsp_err), 32'(e[0]));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2, 2'b00, 8'hF0, 8'h3C, 8'hCF, 1'b0};
    vecs[1] = '{1, 2'b01, 8'h55, 8'h00, 8'hAA, 1'b0};
    vecs[2] = '{3, 2'b11, 8'hFF, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{0, 2'b10, 8'h12, 8'h00, 8'h12, 1'b0};
    vecs[4] = '{0, 2'b00, 8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[5] = '{1, 2'b00, 8'h00, 8'hA5, 8'hFF, 1'b0};
    vecs[6] = '{2, 2'b01, 8'h0F, 8'h77, 8'hF0, 1'b0};
    vecs[7] = '{3, 2'b10, 8'hA5, 8'h5A, 8'hA5, 1'b0};
    vecs[8] = '{3, 2'b00, 8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[9] = '{2, 2'b11, 8'h00, 8'hFF, 8'h00, 1'b1};

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_stat", 32'(stat_count), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // single-requester table, issued back to back
    for (int k = 0; k < 10; k++) begin
      clear_inputs();
      set_req(vecs[k].id, vecs[k].op, vecs[k].a1, vecs[k].a2);
      @(negedge clk);
      expect_grant("table_ready", vecs[k].id, vecs[k].exp_data, vecs[k].exp_err);
      next_cycle();
    end
    drain();

    // fairness from pointer 0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b10, 8'(8'h10 + i), 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expect_grant("fair_ready", c % NUM_REQ, 8'(8'h10 + (c % NUM_REQ)), 1'b0);
      next_cycle();
    end
    drain();

    // backpressure: pointer is 1 here
    set_req(1, 2'b01, 8'h55, 8'h00);
    rsp_ready = 1'b0;
    @(negedge clk);
    expect_grant("bp_first_ready", 1, 8'hAA, 1'b0);
    next_cycle();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b10, 8'(8'h20 + i), 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready_zero", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_data", 32'(rsp_data), 32'hAA);
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    expect_grant("bp_release_ready", 2, 8'h22, 1'b0);
    next_cycle();
    drain();

    // pointer is 3; only req 2 valid forces a wrap, then reset while FULL
    set_req(2, 2'b10, 8'h77, 8'h00);
    rsp_ready = 1'b0;
    @(negedge clk);
    expect_grant("wrap_ready", 2, 8'h77, 1'b0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(rsp_valid), 32'd0);
    check("async_reset_data", 32'(rsp_data), 32'd0);
    exp_q.delete();
    next_cycle();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_req(1, 2'b10, 8'h31, 8'h00);
    set_req(3, 2'b10, 8'h33, 8'h00);
    @(negedge clk);
    expect_grant("post_reset_ready", 1, 8'h31, 1'b0);
    next_cycle();
    drain();

    // four more responses: five completed since the last reset
    for (int i = 0; i < NUM_REQ; i++) begin
      clear_inputs();
      set_req(i, 2'b01, 8'(8'hF0 + i), 8'h00);
      @(negedge clk);
      expect_grant("stat_ready", i, ~8'(8'hF0 + i), 1'b0);
      next_cycle();
    end
    drain();
    @(negedge clk);
`ifdef GATE_ARB_STATS_EN
    check("stat_five", 32'(stat_count), 32'd5);
    next_cycle();
    force dut.stat_q = 16'hFFFF;
    #1;
    release dut.stat_q;
    set_req(0, 2'b10, 8'h5C, 8'h00);
    @(negedge clk);
    expect_grant("sat_ready", 0, 8'h5C, 1'b0);
    next_cycle();
    drain();
    @(negedge clk);
    check("stat_saturate", 32'(stat_count), 32'hFFFF);
`else
    check("stat_disabled", 32'(stat_count), 32'd0);
`endif
    next_cycle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
